// File: rtl/chip8_sprite_drawer.sv
// Sequencer for the CHIP-8 DXYN draw: fetches sprite rows, hands each to the external
// XOR row stage, commits the updated framebuffer and reports the collision flag in VF.
module chip8_sprite_drawer #(
  parameter int ADDR_W     = 12,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cls,
  input  logic [7:0]        vx,
  input  logic [7:0]        vy,
  input  logic [3:0]        n,
  input  logic [ADDR_W-1:0] i_reg,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  output logic              draw,
  output logic [5:0]        x,
  output logic [4:0]        y,
  output logic [3:0]        row_index,
  output logic [7:0]        sprite_data,
  input  logic [2047:0]     display_next,
  input  logic              collision_in,
  output logic [2047:0]     display,
  output logic              busy,
  output logic              done,
  output logic              vf_we,
  output logic [7:0]        vf_out
);

  // Handshake: start/cls are single-cycle requests honoured only while busy=0;
  // anything arriving while busy=1 is dropped. done pulses once per accepted request.

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_DRAW, S_FIN, S_CLR
  } state_t;

  localparam logic [1:0] WAIT_LAST = 2'(RD_LATENCY - 1);

  state_t              state_q, state_d;
  logic [5:0]          x_q, x_d;
  logic [4:0]          y_q, y_d;
  logic [3:0]          n_q, n_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [3:0]          row_q, row_d;
  logic [7:0]          spr_q, spr_d;
  logic [1:0]          wcnt_q, wcnt_d;
  logic                acc_q, acc_d;
  logic [2047:0]       disp_q, disp_d;

  // Upper bits of vx/vy are discarded: the screen is 64x32.
  logic unused_coord_bits;
  assign unused_coord_bits = ^{vx[7:6], vy[7:5]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      n_q     <= '0;
      base_q  <= '0;
      row_q   <= '0;
      spr_q   <= '0;
      wcnt_q  <= '0;
      acc_q   <= 1'b0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      n_q     <= n_d;
      base_q  <= base_d;
      row_q   <= row_d;
      spr_q   <= spr_d;
      wcnt_q  <= wcnt_d;
      acc_q   <= acc_d;
      disp_q  <= disp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    n_d     = n_q;
    base_d  = base_q;
    row_d   = row_q;
    spr_d   = spr_q;
    wcnt_d  = wcnt_q;
    acc_d   = acc_q;
    disp_d  = disp_q;
    mem_rd  = 1'b0;
    draw    = 1'b0;
    done    = 1'b0;
    vf_we   = 1'b0;
    vf_out  = 8'h00;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d     = vx[5:0];
          y_d     = vy[4:0];
          n_d     = n;
          base_d  = i_reg;
          row_d   = '0;
          acc_d   = 1'b0;
          state_d = (n == 4'd0) ? S_FIN : S_FETCH;
        end else if (cls) begin
          state_d = S_CLR;
        end
      end
      S_FETCH: begin
        mem_rd  = 1'b1;
        wcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wcnt_q == WAIT_LAST) begin
          spr_d   = mem_rdata;
          state_d = S_DRAW;
        end else begin
          wcnt_d = wcnt_q + 2'd1;
        end
      end
      S_DRAW: begin
        draw   = 1'b1;
        disp_d = display_next;
        acc_d  = acc_q | collision_in;
        if (row_q == n_q - 4'd1) begin
          state_d = S_FIN;
        end else begin
          row_d   = row_q + 4'd1;
          state_d = S_FETCH;
        end
      end
      S_FIN: begin
        done    = 1'b1;
        vf_we   = 1'b1;
        vf_out  = {7'b0, acc_q};
        state_d = S_IDLE;
      end
      S_CLR: begin
        disp_d  = '0;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_addr    = base_q + ADDR_W'(row_q);
  assign x           = x_q;
  assign y           = y_q;
  assign row_index   = row_q;
  assign sprite_data = spr_q;
  assign display     = disp_q;
  assign busy        = (state_q != S_IDLE);

endmodule
